// File: rtl/linear_feeder_if.sv
// Operand-pair stream from linear_feeder to the MAC stage.
// The feeder drives the master side and the consumer drives out_ready.
interface linear_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NEURON_W   = 1
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] x_out;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  out_last;
  logic [NEURON_W-1:0]   out_neuron;

  modport master (
    output out_valid, x_out, w_out, out_last, out_neuron,
    input  out_ready
  );

  modport slave (
    input  out_valid, x_out, w_out, out_last, out_neuron,
    output out_ready
  );
endinterface

// File: rtl/linear_feeder.sv
// Streams (activation, weight) pairs for a fully connected layer out of two
// synchronous-read memories, through a 2-entry buffer, one pair per cycle.
module linear_feeder #(
  parameter int INPUT_SIZE  = 4096,
  parameter int OUTPUT_SIZE = 2,
  parameter int DATA_WIDTH  = 8,
  localparam int AW  = $clog2(INPUT_SIZE),
  localparam int WAW = $clog2(INPUT_SIZE * OUTPUT_SIZE),
  localparam int NW  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  x_rd_en,
  output logic [AW-1:0]         x_addr,
  input  logic [DATA_WIDTH-1:0] x_rd_data,
  output logic                  w_rd_en,
  output logic [WAW-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0] w_rd_data,
  linear_feeder_if.master       st
);

  localparam logic [AW-1:0] I_LAST = AW'(INPUT_SIZE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUTPUT_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [AW-1:0]   i_r;
  logic [NW-1:0]   n_r;
  logic [WAW-1:0]  w_addr_r;
  logic            inflight_r;
  logic [AW-1:0]   tag_i_r;
  logic [NW-1:0]   tag_n_r;
  logic            busy_r, done_r;

  logic [DATA_WIDTH-1:0] fx_r [2];
  logic [DATA_WIDTH-1:0] fw_r [2];
  logic                  fl_r [2];
  logic [NW-1:0]         fn_r [2];
  logic                  wp_r, rp_r;
  logic [1:0]            count_r;

  logic       pop_s, issue_s, done_s, last_rd_s, room_s;
  logic [2:0] occ_s;

  assign pop_s     = (count_r != 2'd0) && st.out_ready;
  assign last_rd_s = (i_r == I_LAST) && (n_r == N_LAST);
  // Occupancy the buffer will have once everything already requested has landed.
  assign occ_s     = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign room_s    = (occ_s < 3'd2);

  // Next-state, read-issue and done decode.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          issue_s = 1'b1;
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        issue_s = room_s;
        if (room_s && last_rd_s) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        if ((count_r == 2'd1) && !inflight_r && pop_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with busy/done status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE) || done_s;
      done_r  <= done_s;
    end
  end

  // Read address counters and the tag of the read currently in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r        <= {AW{1'b0}};
      n_r        <= {NW{1'b0}};
      w_addr_r   <= {WAW{1'b0}};
      inflight_r <= 1'b0;
      tag_i_r    <= {AW{1'b0}};
      tag_n_r    <= {NW{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        tag_i_r  <= i_r;
        tag_n_r  <= n_r;
        w_addr_r <= last_rd_s ? {WAW{1'b0}} : w_addr_r + {{(WAW-1){1'b0}}, 1'b1};
        if (i_r == I_LAST) begin
          i_r <= {AW{1'b0}};
          n_r <= (n_r == N_LAST) ? {NW{1'b0}} : n_r + {{(NW-1){1'b0}}, 1'b1};
        end else begin
          i_r <= i_r + {{(AW-1){1'b0}}, 1'b1};
          n_r <= n_r;
        end
      end else begin
        tag_i_r <= tag_i_r;
      end
    end
  end

  // Two-entry output buffer; read data lands here the cycle after its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        fx_r[k] <= {DATA_WIDTH{1'b0}};
        fw_r[k] <= {DATA_WIDTH{1'b0}};
        fl_r[k] <= 1'b0;
        fn_r[k] <= {NW{1'b0}};
      end
      wp_r    <= 1'b0;
      rp_r    <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (inflight_r) begin
        fx_r[wp_r] <= x_rd_data;
        fw_r[wp_r] <= w_rd_data;
        fl_r[wp_r] <= (tag_i_r == I_LAST);
        fn_r[wp_r] <= tag_n_r;
        wp_r       <= ~wp_r;
      end else begin
        wp_r <= wp_r;
      end
      if (pop_s) begin
        rp_r <= ~rp_r;
      end else begin
        rp_r <= rp_r;
      end
      count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign x_rd_en       = issue_s;
  assign w_rd_en       = issue_s;
  assign x_addr        = i_r;
  assign w_addr        = w_addr_r;
  assign st.out_valid  = (count_r != 2'd0);
  assign st.x_out      = fx_r[rp_r];
  assign st.w_out      = fw_r[rp_r];
  assign st.out_last   = fl_r[rp_r];
  assign st.out_neuron = fn_r[rp_r];

endmodule

// File: tb/tb_linear_feeder.sv
// Scoreboard bench for linear_feeder (INPUT_SIZE=4, OUTPUT_SIZE=2): stimulus
// queues the expected pairs, an independent monitor checks each handshake.
module tb_linear_feeder;
  localparam int IN = 4;
  localparam int ON = 2;
  localparam int DW = 8;

  typedef struct packed {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] w;
    logic                 last;
    logic                 n;
  } pair_t;

  localparam int EXP_X [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
  localparam int EXP_W [8] = '{-1, -2, -3, -4, -5, -6, -7, -8};
  localparam int EXP_L [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  localparam int EXP_N [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done;
  logic          x_rd_en, w_rd_en;
  logic [1:0]    x_addr;
  logic [2:0]    w_addr;
  logic [DW-1:0] x_rd_data = '0;
  logic [DW-1:0] w_rd_data = '0;

  linear_feeder_if #(.DATA_WIDTH(DW), .NEURON_W(1)) st ();

  linear_feeder #(.INPUT_SIZE(IN), .OUTPUT_SIZE(ON), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .x_rd_en(x_rd_en), .x_addr(x_addr), .x_rd_data(x_rd_data),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .st(st)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  pair_t sb [$];
  int    accepted = 0;
  int    done_count = 0;
  int    done_cyc = -1;
  int    first_valid = -1;
  int    sum0 = 0;
  int    sum1 = 0;
  bit    bp_mode = 1'b0;
  int    bp_k = 0;
  bit    stall_prev = 1'b0;
  pair_t saved;
  int    tstart;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory models: x[i] = i+1, w[a] = -(a+1).
  always @(posedge clk) begin
    if (x_rd_en) x_rd_data <= DW'(int'(x_addr) + 1);
    if (w_rd_en) w_rd_data <= DW'(-(int'(w_addr) + 1));
  end

  // Consumer ready: held high, or the 1,0,0,1 pattern under backpressure.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      st.out_ready = (bp_k == 0 || bp_k == 3);
      bp_k = (bp_k + 1) % 4;
    end else begin
      st.out_ready = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability and done.
  always @(negedge clk) begin
    pair_t cur, e;
    cur = '{x: st.x_out, w: st.w_out, last: st.out_last, n: st.out_neuron};
    if (rst_n) begin
      if (st.out_valid && first_valid < 0) first_valid = cyc;
      if (stall_prev) begin
        n_chk++;
        if (st.out_valid && cur == saved) n_pass++;
        else $display("FAIL stall_hold: actual v=%0b %h required v=1 %h", st.out_valid, cur, saved);
      end
      stall_prev = st.out_valid && !st.out_ready;
      saved = cur;
      if (st.out_valid && st.out_ready) begin
        accepted++;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL extra_pair: actual x=%0d w=%0d required none", cur.x, cur.w);
        end else begin
          e = sb.pop_front();
          if (cur == e) n_pass++;
          else $display("FAIL pair: actual x=%0d w=%0d last=%0b n=%0b required x=%0d w=%0d last=%0b n=%0b",
                        cur.x, cur.w, cur.last, cur.n, e.x, e.w, e.last, e.n);
        end
        if (cur.n) sum1 += int'(cur.x) * int'(cur.w);
        else       sum0 += int'(cur.x) * int'(cur.w);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        chk("busy_at_done", int'(busy), 1);
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_exp();
    for (int k = 0; k < 8; k++)
      sb.push_back('{x: DW'(EXP_X[k]), w: DW'(EXP_W[k]), last: EXP_L[k][0], n: EXP_N[k][0]});
  endtask

  task automatic clear_run();
    accepted = 0; sum0 = 0; sum1 = 0; first_valid = -1; done_cyc = -1;
  endtask

  // Start sampled at the coming edge; tstart is the spec's cycle T.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tstart = cyc - 1;
    chk("busy_T+1", int'(busy), 1);
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (done_count < target && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (done_count < target) begin
      n_chk++;
      $display("FAIL done_timeout: actual done_count %0d required %0d", done_count, target);
    end
  endtask

  task automatic wait_cyc(input int c);
    int b;
    b = 0;
    while (cyc < c && b < 200) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_accepted"}, accepted, 8);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_sum0"}, sum0, -30);
    chk({tag, "_sum1"}, sum1, -70);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    st.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({busy, done, x_rd_en, w_rd_en, x_addr, w_addr, st.out_valid,
              st.x_out, st.w_out, st.out_last, st.out_neuron}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic streaming with out_ready held high.
    clear_run(); push_exp(); do_start(); wait_done(1);
    chk("first_valid_latency", first_valid - tstart, 2);
    chk("done_latency", done_cyc - tstart, 10);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    check_run("basic");

    // Backpressure.
    repeat (3) @(negedge clk);
    bp_mode = 1'b1;
    clear_run(); push_exp(); do_start(); wait_done(2);
    check_run("bp");
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Start while busy is ignored.
    dc = done_count;
    clear_run(); push_exp(); do_start();
    wait_cyc(tstart + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dc + 1);
    repeat (20) @(negedge clk);
    chk("busy_start_done_count", done_count - dc, 1);
    check_run("busy_start");

    // Reset mid-run aborts without done.
    dc = done_count;
    clear_run(); push_exp(); do_start();
    wait_cyc(tstart + 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({busy, done, x_rd_en, w_rd_en, x_addr, w_addr, st.out_valid,
              st.x_out, st.w_out, st.out_last, st.out_neuron}), 0);
    sb.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", done_count - dc, 0);
    clear_run(); push_exp(); do_start(); wait_done(dc + 1);
    chk("restart_first_valid", first_valid - tstart, 2);
    check_run("restart");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
